// File: rtl/seq_det_pkg.sv
`default_nettype none
// ============================================================================
// seq_det_pkg : shared state encoding and default geometry for seq_det_ctrl
// Rev 1.0
// ============================================================================
package seq_det_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    LOAD  = 3'd2,
    SHIFT = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam int W_DEF     = 8;
  localparam int LEN_W_DEF = 8;
  localparam int BIT_W     = $clog2(W_DEF);
  localparam int POS_W     = LEN_W_DEF + BIT_W;

endpackage
`default_nettype wire

// File: rtl/seq_det_ctrl_if.sv
`default_nettype none
// ============================================================================
// seq_det_ctrl_if : host-side frame, word and result signals of seq_det_ctrl
// Rev 1.0
// ============================================================================
interface seq_det_ctrl_if #(
  parameter int W     = 8,
  parameter int LEN_W = 8,
  parameter int CNT_W = 16,
  parameter int POS_W = LEN_W + $clog2(W)
);
  logic             start;
  logic [LEN_W-1:0] frame_len;
  logic [W-1:0]     s_data;
  logic             s_valid;
  logic             s_ready;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] match_cnt;
  logic [POS_W-1:0] first_pos;
  logic             first_vld;

  modport master (
    output start, frame_len, s_data, s_valid,
    input  s_ready, busy, done, match_cnt, first_pos, first_vld
  );

  modport slave (
    input  start, frame_len, s_data, s_valid,
    output s_ready, busy, done, match_cnt, first_pos, first_vld
  );
endinterface
`default_nettype wire

// File: rtl/det_lat_pipe.sv
`default_nettype none
// ============================================================================
// det_lat_pipe : DEPTH-stage delay line aligning {enable, bit index} with det_out
// Rev 1.0
// ============================================================================
module det_lat_pipe #(
  parameter int DEPTH = 1,
  parameter int IDX_W = 11
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_en,
  input  wire logic [IDX_W-1:0] i_idx,
  output logic                  o_en,
  output logic      [IDX_W-1:0] o_idx
);
  logic [DEPTH-1:0] r_en;
  logic [IDX_W-1:0] r_idx [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_en <= '0;
      for (int i = 0; i < DEPTH; i++) r_idx[i] <= '0;
    end else begin
      r_en[0]  <= i_en;
      r_idx[0] <= i_idx;
      for (int i = 1; i < DEPTH; i++) begin
        r_en[i]  <= r_en[i-1];
        r_idx[i] <= r_idx[i-1];
      end
    end
  end

  assign o_en  = r_en[DEPTH-1];
  assign o_idx = r_idx[DEPTH-1];
endmodule
`default_nettype wire

// File: rtl/seq_det_ctrl.sv
`default_nettype none
// ============================================================================
// seq_det_ctrl : frames parallel words into a serial sequence detector and
//                reports match count and first match position. Rev 1.0
// ============================================================================
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int LEN_W   = LEN_W_DEF,
  parameter int DET_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  wire logic       clk,
  input  wire logic       rst,
  seq_det_ctrl_if.slave   host,
  output logic            det_rst,
  output logic            det_in,
  output logic            det_en,
  input  wire logic       det_out
);
  localparam int c_BIT_W = $clog2(W);
  localparam int c_POS_W = LEN_W + c_BIT_W;

  state_t               r_state, w_next;
  logic [LEN_W-1:0]     r_len;
  logic                 r_zero;
  logic [W-1:0]         r_sreg;
  logic [LEN_W-1:0]     r_word_cnt;
  logic [c_POS_W-1:0]   r_bit_idx;
  logic [2:0]           r_drain;
  logic [CNT_W-1:0]     r_match_cnt;
  logic [c_POS_W-1:0]   r_first_pos;
  logic                 r_first_vld;

  logic w_clear, w_s_ready, w_det_en, w_det_in, w_busy, w_done;
  logic w_last_bit, w_last_word, w_drain_end;
  logic                 w_d_en;
  logic [c_POS_W-1:0]   w_d_idx;

  assign w_last_bit  = &r_bit_idx[c_BIT_W-1:0];
  assign w_last_word = (r_word_cnt == r_len);
  assign w_drain_end = (r_drain == 3'(DET_LAT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // A zero-length frame still spends one cycle in CLEAR (results zeroed,
  // det_rst masked) so done lands two cycles after start.
  always_comb begin
    w_next    = r_state;
    w_clear   = 1'b0;
    w_s_ready = 1'b0;
    w_det_en  = 1'b0;
    w_det_in  = 1'b0;
    w_busy    = 1'b1;
    w_done    = 1'b0;
    case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (host.start) w_next = CLEAR;
      end
      CLEAR: begin
        w_clear = 1'b1;
        w_next  = r_zero ? DONE : LOAD;
      end
      LOAD: begin
        w_s_ready = 1'b1;
        if (host.s_valid) w_next = SHIFT;
      end
      SHIFT: begin
        w_det_en = 1'b1;
        w_det_in = r_sreg[W-1];
        if (w_last_bit) w_next = w_last_word ? DRAIN : LOAD;
      end
      DRAIN: if (w_drain_end) w_next = DONE;
      DONE: begin
        w_done = 1'b1;
        w_next = IDLE;
      end
      default: begin
        w_busy = 1'b0;
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len       <= '0;
      r_zero      <= 1'b0;
      r_sreg      <= '0;
      r_word_cnt  <= '0;
      r_bit_idx   <= '0;
      r_drain     <= '0;
      r_match_cnt <= '0;
      r_first_pos <= '0;
      r_first_vld <= 1'b0;
    end else begin
      if (r_state == IDLE && host.start) begin
        r_len  <= host.frame_len;
        r_zero <= (host.frame_len == '0);
      end
      if (w_clear) begin
        r_word_cnt  <= '0;
        r_bit_idx   <= '0;
        r_match_cnt <= '0;
        r_first_pos <= '0;
        r_first_vld <= 1'b0;
      end else if (w_d_en && det_out) begin
        if (!(&r_match_cnt)) r_match_cnt <= r_match_cnt + 1'b1;
        if (!r_first_vld) begin
          r_first_pos <= w_d_idx;
          r_first_vld <= 1'b1;
        end
      end
      if (r_state == LOAD && host.s_valid) begin
        r_sreg     <= host.s_data;
        r_word_cnt <= r_word_cnt + 1'b1;
      end
      if (r_state == SHIFT) begin
        r_sreg    <= {r_sreg[W-2:0], 1'b0};
        r_bit_idx <= r_bit_idx + 1'b1;
      end
      r_drain <= (r_state == DRAIN) ? r_drain + 3'd1 : 3'd0;
    end
  end

  det_lat_pipe #(
    .DEPTH (DET_LAT),
    .IDX_W (c_POS_W)
  ) u_lat_pipe (
    .clk   (clk),
    .rst   (rst),
    .i_en  (w_det_en),
    .i_idx (r_bit_idx),
    .o_en  (w_d_en),
    .o_idx (w_d_idx)
  );

  assign det_rst        = rst | (w_clear & ~r_zero);
  assign det_en         = w_det_en;
  assign det_in         = w_det_in;
  assign host.s_ready   = w_s_ready;
  assign host.busy      = w_busy;
  assign host.done      = w_done;
  assign host.match_cnt = r_match_cnt;
  assign host.first_pos = r_first_pos;
  assign host.first_vld = r_first_vld;
endmodule
`default_nettype wire

// File: tb/tb_seq_det_ctrl.sv
`default_nettype none
// ============================================================================
// tb_seq_det_ctrl : directed bench with a "1101" Moore detector and a results
//                   scoreboard; a CNT_W=2 twin runs in lockstep. Rev 1.0
// ============================================================================
module tb_seq_det_ctrl;
  import seq_det_pkg::*;

  localparam int W = 8, LEN_W = 8, DET_LAT = 1, CNT_W = 16, SAT_W = 2;
  localparam int PW = POS_W;

  typedef struct {
    int   cnt;
    int   pos;
    logic vld;
    int   lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int t0 = 0;
  exp_t sb[$];
  logic [7:0] wq[$];

  seq_det_ctrl_if #(.W(W), .LEN_W(LEN_W), .CNT_W(CNT_W), .POS_W(PW)) ifm ();
  seq_det_ctrl_if #(.W(W), .LEN_W(LEN_W), .CNT_W(SAT_W), .POS_W(PW)) ifs ();
  assign ifs.start     = ifm.start;
  assign ifs.frame_len = ifm.frame_len;
  assign ifs.s_data    = ifm.s_data;
  assign ifs.s_valid   = ifm.s_valid;

  logic m_det_rst, m_det_in, m_det_en, m_det_out;
  logic s_det_rst, s_det_in, s_det_en, s_det_out;

  seq_det_ctrl #(.W(W), .LEN_W(LEN_W), .DET_LAT(DET_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .host(ifm),
    .det_rst(m_det_rst), .det_in(m_det_in), .det_en(m_det_en), .det_out(m_det_out)
  );

  seq_det_ctrl #(.W(W), .LEN_W(LEN_W), .DET_LAT(DET_LAT), .CNT_W(SAT_W)) dut_sat (
    .clk(clk), .rst(rst), .host(ifs),
    .det_rst(s_det_rst), .det_in(s_det_in), .det_en(s_det_en), .det_out(s_det_out)
  );

  // Overlapping "1101" Moore detector: 0 none, 1 "1", 2 "11", 3 "110", 4 match
  function automatic logic [2:0] det_next(input logic [2:0] s, input logic b);
    case (s)
      3'd0:    return b ? 3'd1 : 3'd0;
      3'd1:    return b ? 3'd2 : 3'd0;
      3'd2:    return b ? 3'd2 : 3'd3;
      3'd3:    return b ? 3'd4 : 3'd0;
      3'd4:    return b ? 3'd2 : 3'd0;
      default: return 3'd0;
    endcase
  endfunction

  logic [2:0] m_ds, s_ds;
  always @(posedge clk) begin
    if (m_det_rst)     m_ds <= 3'd0;
    else if (m_det_en) m_ds <= det_next(m_ds, m_det_in);
    if (s_det_rst)     s_ds <= 3'd0;
    else if (s_det_en) s_ds <= det_next(s_ds, s_det_in);
  end
  assign m_det_out = (m_ds == 3'd4);
  assign s_det_out = (s_ds == 3'd4);

  int clr_pulses = 0;
  always @(negedge clk) if (m_det_rst && !rst) clr_pulses <= clr_pulses + 1;

  function automatic exp_t model(input logic [7:0] w[$], input int lat);
    exp_t e;
    logic [2:0] s = 3'd0;
    e.cnt = 0; e.pos = 0; e.vld = 1'b0; e.lat = lat;
    for (int i = 0; i < w.size(); i++)
      for (int b = 7; b >= 0; b--) begin
        s = det_next(s, w[i][b]);
        if (s == 3'd4) begin
          e.cnt++;
          if (!e.vld) begin
            e.vld = 1'b1;
            e.pos = i * 8 + (7 - b);
          end
        end
      end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start_frame(input int len);
    @(negedge clk);
    ifm.start     = 1'b1;
    ifm.frame_len = LEN_W'(len);
    t0 = cyc;
    @(negedge clk);
    ifm.start = 1'b0;
  endtask

  // Returns at the negedge after the word was taken
  task automatic send_word(input logic [7:0] d, input int stall);
    int n = 0;
    ifm.s_data = d;
    if (stall == 0) ifm.s_valid = 1'b1;
    while (!ifm.s_ready && n < 200) begin @(negedge clk); n++; end
    chk("load_ready", ifm.s_ready, 1);
    for (int i = 0; i < stall; i++) begin
      chk("stall_det_en", m_det_en, 0);
      chk("stall_s_ready", ifm.s_ready, 1);
      @(negedge clk);
    end
    ifm.s_valid = 1'b1;
    @(negedge clk);
    ifm.s_valid = 1'b0;
  endtask

  task automatic wait_done();
    exp_t e;
    int n = 0;
    while (!ifm.done && n < 400) begin @(negedge clk); n++; end
    chk("done_seen", ifm.done, 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.lat > 0) chk("done_latency", 64'(cyc - t0), 64'(e.lat));
      chk("match_cnt", 64'(ifm.match_cnt), 64'(e.cnt));
      chk("first_pos", 64'(ifm.first_pos), 64'(e.pos));
      chk("first_vld", ifm.first_vld, e.vld);
      chk("sat_done", ifs.done, 1);
      chk("sat_match_cnt", 64'(ifs.match_cnt), 64'((e.cnt > 3) ? 3 : e.cnt));
    end
    @(negedge clk);
    chk("done_one_cycle", ifm.done, 0);
    chk("busy_after_done", ifm.busy, 0);
  endtask

  task automatic run_frame(input int stall1, input int lat);
    sb.push_back(model(wq, lat));
    start_frame(wq.size());
    chk("busy_after_start", ifm.busy, 1);
    for (int i = 0; i < wq.size(); i++) send_word(wq[i], (i == 1) ? stall1 : 0);
    wait_done();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    ifm.start = 1'b0; ifm.frame_len = '0; ifm.s_data = '0; ifm.s_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_det_rst", m_det_rst, 1);
    chk("rst_busy", ifm.busy, 0);
    chk("rst_s_ready", ifm.s_ready, 0);
    chk("rst_det_en", m_det_en, 0);
    chk("rst_match_cnt", 64'(ifm.match_cnt), 0);
    chk("rst_first_vld", ifm.first_vld, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("det_rst_released", m_det_rst, 0);

    // One word 0x6D, valid held: 2 matches, first at bit 4, done at k+12
    wq.delete(); wq.push_back(8'h6D);
    c0 = clr_pulses;
    run_frame(0, 12);
    chk("clear_pulse_once", 64'(clr_pulses - c0), 1);

    // Asynchronous reset in SHIFT of word 0
    start_frame(1);
    send_word(8'h6D, 0);
    chk("pre_rst_det_en", m_det_en, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", ifm.busy, 0);
    chk("arst_done", ifm.done, 0);
    chk("arst_s_ready", ifm.s_ready, 0);
    chk("arst_det_en", m_det_en, 0);
    chk("arst_det_in", m_det_in, 0);
    chk("arst_match_cnt", 64'(ifm.match_cnt), 0);
    chk("arst_first_pos", 64'(ifm.first_pos), 0);
    chk("arst_first_vld", ifm.first_vld, 0);
    chk("arst_det_rst", m_det_rst, 1);
    @(negedge clk);
    rst = 1'b0;
    run_frame(0, 12);

    // Zero-length frame: done at k+2, results zero, no detector clear
    wq.delete();
    c0 = clr_pulses;
    run_frame(0, 2);
    chk("zero_no_clear", 64'(clr_pulses - c0), 0);

    // Two words with a 5-cycle stall before word 1: one match at bit 11
    wq.delete(); wq.push_back(8'h00); wq.push_back(8'hD0);
    run_frame(5, 0);

    // Four 0xDD words: 8 matches, twin saturates at 3
    wq.delete();
    for (int i = 0; i < 4; i++) wq.push_back(8'hDD);
    run_frame(0, 0);

    // start pulsed while busy with a different frame_len is ignored
    wq.delete(); wq.push_back(8'h6D);
    sb.push_back(model(wq, 12));
    start_frame(1);
    send_word(8'h6D, 0);
    @(negedge clk);
    ifm.start = 1'b1; ifm.frame_len = 8'd3;
    @(negedge clk);
    ifm.start = 1'b0;
    wait_done();
    repeat (3) @(negedge clk);
    chk("no_restart_busy", ifm.busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
